// File: rtl/aes_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

  localparam int AES128_NUM_ROUNDS = 10;
  localparam int RK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2
  } ks_state_e;

  function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? x : 8'h00);
      x   = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes128_key_expand_if.sv
// Key-in / round-key-out handshake bundle of the AES-128 key schedule.
interface aes128_key_expand_if;
  import aes_pkg::*;

  logic            flush;
  logic            key_valid;
  logic            key_ready;
  logic [RK_W-1:0] key;
  logic            rk_valid;
  logic            rk_ready;
  logic [RK_W-1:0] rk_data;
  logic [3:0]      rk_round;
  logic            rk_last;
  logic            busy;

  modport master (
    output flush, key_valid, key, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_round, rk_last, busy
  );

  modport slave (
    input  flush, key_valid, key, rk_ready,
    output key_ready, rk_valid, rk_data, rk_round, rk_last, busy
  );
endinterface

// File: rtl/aes_forward_sbox.sv
// Single AES forward S-box lane, purely combinational.
module aes_forward_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sbox_byte(in_byte);
endmodule

// File: rtl/aes_sub_word.sv
// Substitutes SBOX_LANES bytes of a 32-bit word; lane_sel picks which group, byte 0 (MSB) first.
module aes_sub_word #(
  parameter int SBOX_LANES = 4
) (
  input  logic [31:0]             word,
  input  logic [1:0]              lane_sel,
  output logic [SBOX_LANES*8-1:0] sub_bytes
);
  localparam int CHUNK_W = SBOX_LANES * 8;

  logic [7:0] word_bytes_s [4];

  for (genvar j = 0; j < 4; j++) begin : g_bytes
    assign word_bytes_s[j] = word[31-8*j -: 8];
  end

  for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
    aes_forward_sbox u_sbox (
      .in_byte (word_bytes_s[2'(32'(lane_sel) * SBOX_LANES + i)]),
      .out_byte(sub_bytes[CHUNK_W-1-8*i -: 8])
    );
  end
endmodule

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 forward key schedule: accepts a cipher key and streams round keys 0..10.
module aes128_key_expand
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input logic               clk,
  input logic               rst,
  aes128_key_expand_if.slave bus
);
  localparam int         CHUNK_W   = SBOX_LANES * 8;
  localparam logic [1:0] LAST_LANE = 2'(4 / SBOX_LANES - 1);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
    $error("aes128_key_expand: SBOX_LANES must be 1, 2 or 4");
  end

  ks_state_e          state_r;
  ks_state_e          next_state_s;
  logic [RK_W-1:0]    rk_data_r;
  logic [RK_W-1:0]    next_key_s;
  logic [3:0]         rk_round_r;
  logic               rk_valid_r;
  logic [1:0]         lane_cnt_r;
  logic [31:0]        temp_r;
  logic [31:0]        temp_shift_s;
  logic [31:0]        rot_w3_s;
  logic [31:0]        t_s;
  logic [CHUNK_W-1:0] sub_s;
  logic               last_lane_s;
  logic               final_round_s;
  logic               rk_hs_s;

  assign rot_w3_s      = {rk_data_r[23:0], rk_data_r[31:24]};
  assign last_lane_s   = (lane_cnt_r == LAST_LANE);
  assign final_round_s = (rk_round_r == 4'(AES128_NUM_ROUNDS));
  assign rk_hs_s       = rk_valid_r & bus.rk_ready;

  // The S-box input comes only from registered state, never from rk_ready.
  aes_sub_word #(.SBOX_LANES(SBOX_LANES)) u_sub_word (
    .word     (rot_w3_s),
    .lane_sel (lane_cnt_r),
    .sub_bytes(sub_s)
  );

  // Earlier groups shift up so the first substituted byte ends in the MSB.
  assign temp_shift_s = (temp_r << CHUNK_W) | 32'(sub_s);

  // Next round key from the completed SubWord(RotWord(w3)).
  always_comb begin
    t_s = temp_shift_s ^ {rcon_lookup(rk_round_r + 4'd1), 24'h000000};
    next_key_s[127:96] = rk_data_r[127:96] ^ t_s;
    next_key_s[95:64]  = rk_data_r[95:64] ^ rk_data_r[127:96] ^ t_s;
    next_key_s[63:32]  = rk_data_r[63:32] ^ rk_data_r[95:64] ^ rk_data_r[127:96] ^ t_s;
    next_key_s[31:0]   = rk_data_r[31:0] ^ rk_data_r[63:32] ^ rk_data_r[95:64] ^
                         rk_data_r[127:96] ^ t_s;
  end

  // Next-state decode; flush overrides every handshake.
  always_comb begin
    next_state_s = state_r;
    if (bus.flush) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = bus.key_valid ? EMIT : IDLE;
        EMIT:    next_state_s = rk_hs_s ? (final_round_s ? IDLE : SUB) : EMIT;
        SUB:     next_state_s = last_lane_s ? EMIT : SUB;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Round key, round index, lane counter and SubWord accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_valid_r <= 1'b0;
      rk_data_r  <= {RK_W{1'b0}};
      rk_round_r <= 4'd0;
      lane_cnt_r <= 2'd0;
      temp_r     <= 32'd0;
    end else if (bus.flush) begin
      rk_valid_r <= 1'b0;
      rk_round_r <= 4'd0;
      lane_cnt_r <= 2'd0;
      temp_r     <= 32'd0;
    end else begin
      rk_valid_r <= (next_state_s == EMIT);
      case (state_r)
        IDLE: begin
          if (bus.key_valid) begin
            rk_data_r  <= bus.key;
            rk_round_r <= 4'd0;
          end
        end
        EMIT: begin
          if (rk_hs_s) begin
            lane_cnt_r <= 2'd0;
            temp_r     <= 32'd0;
          end
        end
        SUB: begin
          temp_r <= temp_shift_s;
          if (last_lane_s) begin
            rk_data_r  <= next_key_s;
            rk_round_r <= rk_round_r + 4'd1;
            lane_cnt_r <= 2'd0;
          end else begin
            lane_cnt_r <= lane_cnt_r + 2'd1;
          end
        end
        default: begin
          lane_cnt_r <= 2'd0;
        end
      endcase
    end
  end

  assign bus.key_ready = (state_r == IDLE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.rk_valid  = rk_valid_r;
  assign bus.rk_data   = rk_data_r;
  assign bus.rk_round  = rk_round_r;
  assign bus.rk_last   = rk_valid_r & final_round_s;
endmodule

// File: tb/tb_aes128_key_expand.sv
// Bench for aes128_key_expand: three lane configurations against a table-driven FIPS-197 model.
module tb_aes128_key_expand;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk;
  logic         rst;
  logic         flush_d;
  logic         key_valid_d;
  logic         rk_ready_d;
  logic [127:0] key_d;

  int vectors     = 0;
  int miscompares = 0;
  int spacing [3] = '{2, 3, 5};

  logic [7:0]   sbox_t [256];
  logic [127:0] golden [11];

  logic         rk_valid_w  [3];
  logic [127:0] rk_data_w   [3];
  logic [3:0]   rk_round_w  [3];
  logic         rk_last_w   [3];
  logic         busy_w      [3];
  logic         key_ready_w [3];

  aes128_key_expand_if if4 ();
  aes128_key_expand_if if2 ();
  aes128_key_expand_if if1 ();

  aes128_key_expand #(.SBOX_LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  aes128_key_expand #(.SBOX_LANES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  aes128_key_expand #(.SBOX_LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if4.flush = flush_d;  assign if4.key_valid = key_valid_d;
  assign if4.key = key_d;      assign if4.rk_ready = rk_ready_d;
  assign if2.flush = flush_d;  assign if2.key_valid = key_valid_d;
  assign if2.key = key_d;      assign if2.rk_ready = rk_ready_d;
  assign if1.flush = flush_d;  assign if1.key_valid = key_valid_d;
  assign if1.key = key_d;      assign if1.rk_ready = rk_ready_d;

  assign rk_valid_w[0] = if4.rk_valid;  assign rk_data_w[0] = if4.rk_data;
  assign rk_round_w[0] = if4.rk_round;  assign rk_last_w[0] = if4.rk_last;
  assign busy_w[0] = if4.busy;          assign key_ready_w[0] = if4.key_ready;
  assign rk_valid_w[1] = if2.rk_valid;  assign rk_data_w[1] = if2.rk_data;
  assign rk_round_w[1] = if2.rk_round;  assign rk_last_w[1] = if2.rk_last;
  assign busy_w[1] = if2.busy;          assign key_ready_w[1] = if2.key_ready;
  assign rk_valid_w[2] = if1.rk_valid;  assign rk_data_w[2] = if1.rk_data;
  assign rk_round_w[2] = if1.rk_round;  assign rk_last_w[2] = if1.rk_last;
  assign busy_w[2] = if1.busy;          assign key_ready_w[2] = if1.key_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S-box by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) golden[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic offer_key(input logic [127:0] k);
    key_d       = k;
    key_valid_d = 1'b1;
    tick();
    key_valid_d = 1'b0;
    key_d       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic sync_idle();
    rk_ready_d = 1'b0;
    flush_d    = 1'b1;
    tick();
    flush_d    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({rk_valid_w[d], rk_data_w[d], rk_round_w[d], rk_last_w[d], busy_w[d]} !== 135'd0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: valid=%b data=%h round=%0d last=%b busy=%b, required all 0",
                 d, rk_valid_w[d], rk_data_w[d], rk_round_w[d], rk_last_w[d], busy_w[d]);
      end
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (key_ready_w[d] !== 1'b1 || busy_w[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release dut%0d: key_ready=%b busy=%b, required 1/0", d, key_ready_w[d], busy_w[d]);
      end
    end
  endtask

  task automatic test_fips_a1(input string tag);
    int cnt [3];
    int last_c [3];
    int done_c [3];
    logic [127:0] r1_data;
    logic [127:0] r10_data;
    r1_data  = 128'd0;
    r10_data = 128'd0;
    expand(FIPS_KEY);
    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0; last_c[d] = 0; done_c[d] = -10;
    end
    rk_ready_d = 1'b1;
    offer_key(FIPS_KEY);
    for (int c = 0; c < 80; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (c == done_c[d] + 1) begin
          vectors++;
          if (key_ready_w[d] !== 1'b1 || rk_valid_w[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle_after_r10 dut%0d: key_ready=%b rk_valid=%b, required 1/0",
                     tag, d, key_ready_w[d], rk_valid_w[d]);
          end
        end
        if (rk_valid_w[d] === 1'b1 && cnt[d] >= 11) begin
          vectors++;
          miscompares++;
          $display("FAIL %s_extra_valid dut%0d: rk_valid=1 round=%0d, required no further round key",
                   tag, d, rk_round_w[d]);
        end else if (rk_valid_w[d] === 1'b1) begin
          vectors++;
          if (rk_data_w[d] !== golden[cnt[d]] || rk_round_w[d] !== 4'(cnt[d]) ||
              rk_last_w[d] !== (cnt[d] == 10)) begin
            miscompares++;
            $display("FAIL %s_round dut%0d: data=%h round=%0d last=%b, required %h/%0d/%b",
                     tag, d, rk_data_w[d], rk_round_w[d], rk_last_w[d], golden[cnt[d]], cnt[d], cnt[d] == 10);
          end
          if (cnt[d] > 0) begin
            vectors++;
            if (c - last_c[d] != spacing[d]) begin
              miscompares++;
              $display("FAIL %s_spacing dut%0d round %0d: %0d cycles, required %0d",
                       tag, d, cnt[d], c - last_c[d], spacing[d]);
            end
          end
          if (d == 0 && cnt[d] == 1) r1_data = rk_data_w[d];
          if (d == 0 && cnt[d] == 10) r10_data = rk_data_w[d];
          last_c[d] = c;
          if (cnt[d] == 10) done_c[d] = c;
          cnt[d]++;
        end
      end
      tick();
    end
    vectors++;
    if (r1_data !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      miscompares++;
      $display("FAIL %s_fips_round1: got %h required a0fafe1788542cb123a339392a6c7605", tag, r1_data);
    end
    vectors++;
    if (r10_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      miscompares++;
      $display("FAIL %s_fips_round10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", tag, r10_data);
    end
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (cnt[d] != 11) begin
        miscompares++;
        $display("FAIL %s_round_count dut%0d: %0d round keys, required 11", tag, d, cnt[d]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] k;
    logic [127:0] pd;
    logic [3:0]   pr;
    logic         pv;
    logic         ph;
    logic         hs;
    int           idx;
    int           stall;
    sync_idle();
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    offer_key(k);
    idx = 0; stall = 0; pv = 1'b0; ph = 1'b0; pd = 128'd0; pr = 4'd0;
    for (int c = 0; c < 3000 && idx < 11; c++) begin
      if (pv && !ph) begin
        vectors++;
        if (rk_valid_w[0] !== 1'b1 || rk_data_w[0] !== pd || rk_round_w[0] !== pr) begin
          miscompares++;
          $display("FAIL bp_stable: valid=%b data=%h round=%0d, required 1/%h/%0d",
                   rk_valid_w[0], rk_data_w[0], rk_round_w[0], pd, pr);
        end
      end
      if (rk_valid_w[0] === 1'b1 && rk_round_w[0] == 4'd5 && stall < 20) begin
        rk_ready_d = 1'b0;
        stall++;
      end else begin
        rk_ready_d = ($urandom_range(0, 3) != 0);
      end
      hs = rk_valid_w[0] & rk_ready_d;
      if (hs) begin
        vectors++;
        if (rk_data_w[0] !== golden[idx] || rk_round_w[0] !== 4'(idx) || rk_last_w[0] !== (idx == 10)) begin
          miscompares++;
          $display("FAIL bp_round: data=%h round=%0d last=%b, required %h/%0d/%b",
                   rk_data_w[0], rk_round_w[0], rk_last_w[0], golden[idx], idx, idx == 10);
        end
        idx++;
      end
      pv = rk_valid_w[0]; ph = hs; pd = rk_data_w[0]; pr = rk_round_w[0];
      tick();
    end
    vectors++;
    if (idx != 11 || stall != 20) begin
      miscompares++;
      $display("FAIL bp_complete: %0d round keys, %0d stall cycles, required 11/20", idx, stall);
    end
  endtask

  task automatic test_key_while_busy();
    logic [127:0] k;
    int           idx;
    int           inj;
    sync_idle();
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    rk_ready_d = 1'b1;
    offer_key(k);
    idx = 0; inj = 0;
    for (int c = 0; c < 200 && idx < 11; c++) begin
      if (rk_valid_w[0] === 1'b1 && rk_round_w[0] == 4'd3 && inj < 3) begin
        key_valid_d = 1'b1;
        key_d       = ~k;
        rk_ready_d  = 1'b0;
        inj++;
        vectors++;
        if (key_ready_w[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_key_ready: got %b required 0", key_ready_w[0]);
        end
      end else begin
        key_valid_d = 1'b0;
        rk_ready_d  = 1'b1;
      end
      if (rk_valid_w[0] === 1'b1 && rk_ready_d) begin
        vectors++;
        if (rk_data_w[0] !== golden[idx] || rk_round_w[0] !== 4'(idx)) begin
          miscompares++;
          $display("FAIL busy_round: data=%h round=%0d, required %h/%0d",
                   rk_data_w[0], rk_round_w[0], golden[idx], idx);
        end
        idx++;
      end
      tick();
    end
    key_valid_d = 1'b0;
    vectors++;
    if (idx != 11 || inj != 3 || key_ready_w[0] !== 1'b1 || rk_valid_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_complete: keys=%0d inj=%0d key_ready=%b rk_valid=%b, required 11/3/1/0",
               idx, inj, key_ready_w[0], rk_valid_w[0]);
    end
  endtask

  task automatic test_flush();
    logic [127:0] k;
    logic         found;
    int           idx;
    logic [127:0] r10_data;
    sync_idle();
    k = {$urandom, $urandom, $urandom, $urandom};
    rk_ready_d = 1'b1;
    offer_key(k);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (rk_valid_w[0] === 1'b1 && rk_round_w[0] == 4'd4) found = 1'b1;
      else tick();
    end
    tick();
    vectors++;
    if (!found || busy_w[0] !== 1'b1 || rk_valid_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_setup: found=%b busy=%b rk_valid=%b, required 1/1/0", found, busy_w[0], rk_valid_w[0]);
    end
    flush_d = 1'b1;
    tick();
    flush_d = 1'b0;
    vectors++;
    if (busy_w[0] !== 1'b0 || key_ready_w[0] !== 1'b1 || rk_valid_w[0] !== 1'b0 || rk_round_w[0] !== 4'd0) begin
      miscompares++;
      $display("FAIL flush_idle: busy=%b key_ready=%b rk_valid=%b round=%0d, required 0/1/0/0",
               busy_w[0], key_ready_w[0], rk_valid_w[0], rk_round_w[0]);
    end
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (rk_valid_w[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_no_valid cycle %0d: rk_valid=%b required 0", c, rk_valid_w[0]);
      end
      tick();
    end
    expand(C1_KEY);
    offer_key(C1_KEY);
    idx = 0;
    r10_data = 128'd0;
    for (int c = 0; c < 60 && idx < 11; c++) begin
      if (rk_valid_w[0] === 1'b1) begin
        vectors++;
        if (rk_data_w[0] !== golden[idx] || rk_round_w[0] !== 4'(idx)) begin
          miscompares++;
          $display("FAIL flush_newkey_round: data=%h round=%0d, required %h/%0d",
                   rk_data_w[0], rk_round_w[0], golden[idx], idx);
        end
        if (idx == 10) r10_data = rk_data_w[0];
        idx++;
      end
      tick();
    end
    vectors++;
    if (r10_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      miscompares++;
      $display("FAIL flush_newkey_round10: got %h required 13111d7fe3944a17f307a78b4d2b30c5", r10_data);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    sync_idle();
    rk_ready_d = 1'b1;
    offer_key(FIPS_KEY);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (rk_valid_w[0] === 1'b1 && rk_round_w[0] == 4'd7) found = 1'b1;
      else tick();
    end
    rk_ready_d = 1'b0;
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rstmid_reach_round7: found=%b required 1", found);
    end
    #3;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({rk_valid_w[d], rk_data_w[d], rk_round_w[d], rk_last_w[d], busy_w[d]} !== 135'd0 ||
          key_ready_w[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL rstmid_clear dut%0d: valid=%b data=%h round=%0d last=%b busy=%b key_ready=%b, required zeros and key_ready=1",
                 d, rk_valid_w[d], rk_data_w[d], rk_round_w[d], rk_last_w[d], busy_w[d], key_ready_w[d]);
      end
    end
    #2;
    rst = 1'b0;
    tick();
    vectors++;
    if (key_ready_w[0] !== 1'b1 || rk_valid_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_release: key_ready=%b rk_valid=%b, required 1/0", key_ready_w[0], rk_valid_w[0]);
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush_d     = 1'b0;
    key_valid_d = 1'b0;
    rk_ready_d  = 1'b0;
    key_d       = 128'd0;
    build_sbox();
    test_reset();
    test_fips_a1("a1");
    test_backpressure();
    test_key_while_busy();
    test_flush();
    test_reset_mid();
    test_fips_a1("a1_after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes128_key_expand.md
Name: aes128_key_expand

Overview:
- Sequential AES-128 forward key schedule per FIPS-197.
- Accepts a 128-bit cipher key over a valid/ready handshake and streams round keys 0..10 in order, one per output handshake.
- Computes SubWord with a configurable number of aes_forward_sbox lanes. With fewer lanes it trades latency for area.
- Its round-key stream feeds the AddRoundKey stage of the round datapath.

Parameters:
- SBOX_LANES, 4, number of aes_forward_sbox instances used for SubWord; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  block can accept a key; high only in IDLE.
- key  in  128  cipher key; key[127:96] is w0; the byte in bits [31:24] of a word is byte 0.
- rk_valid  out  1  round key presented.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  128  round key, same packing as key.
- rk_round  out  4  round index 0..10.
- rk_last  out  1  high while rk_round==10.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rk_valid=0, rk_data=0, rk_round=0, rk_last=0, busy=0.
  - key_ready=1 on the first cycle after rst deasserts.
  - Reset mid-operation discards all progress; no partial output follows.
- States: IDLE, EMIT, SUB.
- IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: register key into rk_data, set rk_round=0, go to EMIT.
  - rk_valid rises the following cycle.
- EMIT:
  - rk_valid=1.
  - rk_data and rk_round are held stable until rk_valid&&rk_ready. Backpressure of any length is legal.
  - On handshake with rk_round==10: go to IDLE; rk_valid=0 next cycle.
  - On handshake with rk_round<10: rk_valid=0 next cycle; go to SUB with lane counter=0.
- SUB:
  - Runs for exactly 4/SBOX_LANES cycles.
  - Each cycle, SBOX_LANES bytes of RotWord(w3) are substituted and stored in a temp register, most significant byte first. RotWord maps [a0 a1 a2 a3] to [a1 a2 a3 a0].
  - The sbox input is the registered rk_data. There is no combinational path from rk_ready to the sbox.
  - On the last SUB cycle the next key is registered and rk_round increments:
    - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
  - Then go to EMIT.
  - Net latency is 4/SBOX_LANES + 1 cycles from a round handshake to the next rk_valid: 2 cycles for L=4, 5 cycles for L=1.
- rcon for the round being produced (1..10): 01,02,04,08,10,20,40,80,1B,36 (table lookup, not computed).
- flush (synchronous) from any state: next cycle state=IDLE, rk_valid=0, rk_round=0, key_ready=1. flush has priority over a simultaneous key or round-key handshake.
- key_valid outside IDLE is ignored (key_ready=0). The key input need not stay stable after its handshake.
- rk_last = (rk_round==10) whenever rk_valid=1; otherwise 0.
- All outputs are registered except key_ready, rk_last and busy, which are decoded from the registered state and round.

Decomposition:
- Package aes_pkg:
  - AES128_NUM_ROUNDS=10.
  - rcon byte table indexed 1..10.
  - State enum {IDLE, EMIT, SUB}.
  - Round-key width constant 128.
- Sub-module aes_sub_word:
  - Parameter SBOX_LANES.
  - Input 32-bit word and lane-select index; output SBOX_LANES*8 substituted bits.
  - Instantiates SBOX_LANES aes_forward_sbox.
  - Purely combinational; the top level owns all registers.

Test Plan:
- FIPS-197 A.1 with L=4, rk_ready tied 1:
  - Key 2b7e151628aed2a6abf7158809cf4f3c produces round 0 = key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
  - Successive rk_valid pulses are exactly 2 cycles apart; key_ready=1 the cycle after the round-10 handshake.
- Same vector with L=1 and L=2: identical rk_data sequence; valid-to-valid spacing is 5 and 3 cycles respectively.
- Random rk_ready backpressure, including 20-cycle stalls in round 5:
  - rk_data and rk_round stay stable while stalled.
  - No round is skipped or duplicated; all 11 keys match the golden model.
- Key offered while busy (round 3): key_ready=0 and the key is ignored; the sequence continues to round 10 from the original key.
- flush in SUB after the round-4 handshake: IDLE the next cycle, no rk_valid pulse. A new key 000102030405060708090a0b0c0d0e0f then yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- rst asserted mid-EMIT at round 7 (asynchronously, between clock edges): outputs clear immediately. After release, FIPS A.1 expands correctly from round 0.
